// File: rtl/vv_add_ctrl_pkg.sv
// Shared types and constants for the vv_add sequencer.
// State encoding, result FIFO depth and default widths.
package vv_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int FIFO_DEPTH  = 2;
  localparam int DATA_W_DFLT = 64;
  localparam int IDX_W_DFLT  = 10;

endpackage

// File: rtl/vv_add_skid_fifo.sv
// Two-entry result FIFO between the adder and the C write port.
// Supports push and pop in the same cycle at any occupancy.
module vv_add_skid_fifo
  import vv_add_ctrl_pkg::*;
#(
  parameter int W = DATA_W_DFLT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;

  assign o_head = r_mem[r_rp];
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (i_pop) begin
        r_rp <= ~r_rp;
      end
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/vv_add_seq_ctrl.sv
// Vector-add sequencer: reads A/B, adds, writes C with backpressure.
// Define VV_ADD_SAT_EN for a saturating sum instead of modular wrap.
module vv_add_seq_ctrl
  import vv_add_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int IDX_W  = IDX_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [IDX_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0] a_rdata,
  input  logic [DATA_W-1:0] b_rdata,
  output logic              c_we,
  output logic [IDX_W-1:0]  c_addr,
  output logic [DATA_W-1:0] c_wdata,
  input  logic              c_ready
);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_v;
  logic [IDX_W-1:0]   r_len;
  logic [IDX_W-1:0]   r_rd_idx;
  logic [IDX_W-1:0]   r_wr_cnt;

  logic [1:0]         w_cnt;
  logic [DATA_W-1:0]  w_head;
  logic [DATA_W-1:0]  w_sum;
  logic               w_we;
  logic               w_pop;
  logic               w_rd_en;
  logic [2:0]         w_credit;
  logic [IDX_W-1:0]   w_wr_nxt;

  assign w_we     = (w_cnt != 2'd0);
  assign w_pop    = w_we & c_ready;
  assign w_wr_nxt = r_wr_cnt + IDX_W'(1);

  // Reads in flight plus queued results may never exceed the FIFO.
  assign w_credit = {2'b0, r_v} + {1'b0, w_cnt} - {2'b0, w_pop};
  assign w_rd_en  = (r_state == RUN) && (r_rd_idx < r_len)
                 && (w_credit < 3'd2);

`ifdef VV_ADD_SAT_EN
  logic [DATA_W:0] w_add;
  assign w_add = {1'b0, a_rdata} + {1'b0, b_rdata};
  assign w_sum = w_add[DATA_W] ? {DATA_W{1'b1}} : w_add[DATA_W-1:0];
`else
  assign w_sum = a_rdata + b_rdata;
`endif

  vv_add_skid_fifo #(
    .W (DATA_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_v),
    .i_data (w_sum),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_cnt  (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_v      <= 1'b0;
      r_len    <= '0;
      r_rd_idx <= '0;
      r_wr_cnt <= '0;
    end else begin
      r_v    <= w_rd_en;
      r_done <= 1'b0;
      if (w_rd_en) begin
        r_rd_idx <= r_rd_idx + IDX_W'(1);
      end
      if (w_pop) begin
        r_wr_cnt <= w_wr_nxt;
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_len    <= len;
            r_rd_idx <= '0;
            r_wr_cnt <= '0;
            if (len != '0) begin
              r_state <= RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        RUN: begin
          // Finish on the edge that accepts the final write.
          if (w_pop && (w_wr_nxt == r_len)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rd_en   = w_rd_en;
  assign rd_addr = r_rd_idx;
  assign c_we    = w_we;
  assign c_addr  = r_wr_cnt;
  assign c_wdata = w_head;

endmodule

// File: tb/tb_vv_add_seq_ctrl.sv
// Scoreboard bench for vv_add_seq_ctrl with random data and backpressure.
// Expected C values come from plain arithmetic on the A/B arrays.
module tb_vv_add_seq_ctrl;

  localparam int DW = 64;
  localparam int IW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [IW-1:0] len = '0;
  logic          busy, done, rd_en, c_we;
  logic [IW-1:0] rd_addr, c_addr;
  logic [DW-1:0] a_rdata = '0;
  logic [DW-1:0] b_rdata = '0;
  logic [DW-1:0] c_wdata;
  logic          c_ready = 1'b1;

  always #5 clk = ~clk;

  vv_add_seq_ctrl #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .c_we(c_we),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_ready(c_ready)
  );

  typedef struct {
    logic [IW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] amem [1024];
  logic [DW-1:0] bmem [1024];
  int            cyc = 0;
  int            n_exp = 0;
  int            n_rd = 0;
  int            n_pop = 0;
  int            checks = 0;
  int            errors = 0;
  int            ready_ctl = 0;
  bit            zero_arm = 0;
  bit            fin = 0;
  bit            rst_s = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_s <= rst;

  function automatic logic [DW-1:0] ref_sum(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
`ifdef VV_ADD_SAT_EN
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
`else
    return a + b;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Sync-read memory model for A and B.
  initial begin : memmodel
    logic          rp;
    logic [IW-1:0] ra;
    forever begin
      @(negedge clk);
      rp = rd_en;
      ra = rd_addr;
      @(posedge clk);
      #1;
      if (rp) begin
        a_rdata = amem[ra];
        b_rdata = bmem[ra];
      end else begin
        a_rdata = {$urandom, $urandom};
        b_rdata = {$urandom, $urandom};
      end
    end
  end

  initial begin : readydrv
    forever begin
      @(posedge clk);
      #1;
      if (ready_ctl == 0) c_ready = 1'b1;
      else if (ready_ctl == 1) c_ready = 1'($urandom_range(0, 1));
      else c_ready = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every accepted write.
  initial begin : monitor
    bit            due;
    bit            nd;
    bit            stall;
    logic [IW-1:0] s_addr;
    logic [DW-1:0] s_data;
    exp_t          e;
    due   = 0;
    stall = 0;
    s_addr = '0;
    s_data = '0;
    forever begin
      @(negedge clk);
      nd = 0;
      if (fin) begin
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end else if (rst_s) begin
        chk("reset_outs",
            64'({busy, done, rd_en, c_we, rd_addr, c_addr}), 64'd0);
        chk("reset_wdata", c_wdata, 64'd0);
        n_rd  = 0;
        n_pop = 0;
        stall = 0;
      end else if (!rst) begin
        chk("done", 64'(done), 64'(due));
        if (done) chk("busy_at_done", 64'(busy), 64'd0);
        if (stall) begin
          chk("stall_we", 64'(c_we), 64'd1);
          chk("stall_addr", 64'(c_addr), 64'(s_addr));
          chk("stall_data", c_wdata, s_data);
        end
        if (rd_en) begin
          chk("outstanding_le2", 64'((n_rd - n_pop) <= 2), 64'd1);
          chk("rd_expected", 64'(n_rd < n_exp), 64'd1);
          n_rd++;
        end
        if (c_we && c_ready) begin
          if (sb.size() == 0) begin
            chk("c_we_unexpected", 64'(c_we), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("c_addr", 64'(c_addr), 64'(e.addr));
            chk("c_wdata", c_wdata, e.data);
            chk("busy_run", 64'(busy), 64'd1);
            if (e.cyc >= 0) chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            nd = e.last;
          end
          n_pop++;
        end
        if (start && zero_arm) nd = 1;
        stall  = c_we && !c_ready;
        s_addr = c_addr;
        s_data = c_wdata;
      end else begin
        stall = 0;
      end
      due = nd;
    end
  end

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      amem[i] = {$urandom, $urandom};
      bmem[i] = {$urandom, $urandom};
    end
  endtask

  task automatic run_op(input int n, input bit timed);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.addr = IW'(i);
      e.data = ref_sum(amem[i], bmem[i]);
      e.last = (i == n - 1);
      e.cyc  = timed ? cyc + 3 + i : -1;
      sb.push_back(e);
    end
    n_exp += n;
    zero_arm = (n == 0);
    start = 1'b1;
    len   = IW'(n);
    @(posedge clk);
    #1;
    start    = 1'b0;
    len      = IW'($urandom);
    zero_arm = 0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (sb.size() != 0) begin
      @(posedge clk);
      t++;
      if (t > 3000) begin
        $display("FAIL timeout: %0d writes pending, required 0", sb.size());
        $fatal(1, "timeout");
      end
    end
    repeat (4) @(posedge clk);
  endtask

  initial begin : stim
    int base;
    int t;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      amem[i] = 64'(i + 1);
      bmem[i] = 64'(10 * (i + 1));
    end
    run_op(4, 1);
    wait_idle();

    fill(8);
    run_op(8, 0);
    repeat (3) @(negedge clk);
    ready_ctl = 2;
    repeat (5) @(negedge clk);
    ready_ctl = 0;
    wait_idle();

    run_op(0, 1);
    wait_idle();

    amem[0] = {DW{1'b1}};
    bmem[0] = 64'd2;
    run_op(1, 1);
    wait_idle();

    fill(6);
    base = n_pop;
    run_op(6, 0);
    t = 0;
    while ((n_pop - base) < 3) begin
      @(posedge clk);
      t++;
      if (t > 1000) begin
        $display("FAIL timeout: writes %0d, required 3", n_pop - base);
        $fatal(1, "timeout");
      end
    end
    #1;
    rst = 1'b1;
    sb.delete();
    n_exp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fill(2);
    run_op(2, 1);
    wait_idle();

    fill(8);
    run_op(8, 1);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    len   = IW'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (10) @(posedge clk);

    for (int k = 0; k < 6; k++) begin
      int n;
      ready_ctl = 1;
      n = $urandom_range(1, 24);
      fill(n);
      run_op(n, 0);
      wait_idle();
    end
    ready_ctl = 0;
    repeat (4) @(posedge clk);
    #1;
    fin = 1;
  end

endmodule
